// File: rtl/input_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// input_debouncer_pkg
//   Shared definitions for the input-conditioning blocks: the debouncer FSM
//   state encoding. Other conditioning blocks import the same encoding so
//   that state values read the same everywhere.
// -----------------------------------------------------------------------------
package input_debouncer_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,   // dout agrees with the synchronised input
        ST_WAIT   = 1'b1    // candidate change being qualified
    } db_state_e;

endpackage : input_debouncer_pkg

// File: rtl/input_debouncer_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   N-flop synchroniser bringing an asynchronous level into the clk domain.
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  asynchronous, active-high reset; chain forced to RESET_LEVEL
//     d    in  asynchronous input level
//     q    out synchronised level (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_chain

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Turns a raw, bouncy, asynchronous level into a clean clk-synchronous level
//   plus one-cycle rise/fall pulses. A change is accepted only after the
//   synchronised input has differed from dout for DEBOUNCE_CYCLES consecutive
//   samples with en held high.
//   Ports:
//     clk        in  rising-edge clock
//     rst        in  asynchronous, active-high reset
//     en         in  1 = debounce active, 0 = freeze dout and abort qualification
//     din_async  in  raw input, asynchronous to clk
//     dout       out debounced level
//     rise       out one-cycle pulse on an accepted 0->1 change
//     fall       out one-cycle pulse on an accepted 1->0 change
//     busy       out high while a candidate change is being qualified
// -----------------------------------------------------------------------------
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din_async,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            s;
    db_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            dout_q;
    logic            rise_q;
    logic            fall_q;
    logic            busy_q;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_async),
        .q   (s)
    );

    // FSM, qualification counter and registered outputs. Pulses default low
    // every cycle and are raised only on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= CNT_ZERO;
            dout_q  <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_STABLE: begin
                    if (en && (s != dout_q)) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            dout_q <= s;
                            rise_q <= s;
                            fall_q <= ~s;
                            cnt_q  <= CNT_ZERO;
                        end else begin
                            state_q <= ST_WAIT;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_ONE;
                        end
                    end else begin
                        cnt_q <= CNT_ZERO;
                    end
                end
                ST_WAIT: begin
                    if (!en || (s == dout_q)) begin
                        // Glitch or disable: drop the candidate silently.
                        state_q <= ST_STABLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        dout_q  <= s;
                        rise_q  <= s;
                        fall_q  <= ~s;
                        state_q <= ST_STABLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= CNT_ZERO;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_STABLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule : input_debouncer
